// File: rtl/d_dram_arbiter.sv
// Two-port data-RAM arbiter: grants one byte-addressed request per cycle, extracts and
// extends load lanes, and performs byte/half stores as a two-cycle read-modify-write.
module d_dram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [1:0]        m0_req_size,
    input  logic              m0_req_signed,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [31:0]       m0_req_wdata,
    output logic              m0_rsp_valid,
    output logic [31:0]       m0_rsp_rdata,
    output logic              m0_rsp_err,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [1:0]        m1_req_size,
    input  logic              m1_req_signed,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [31:0]       m1_req_wdata,
    output logic              m1_rsp_valid,
    output logic [31:0]       m1_rsp_rdata,
    output logic              m1_rsp_err,
    output logic [ADDR_W-3:0] ram_addr,
    output logic              ram_wr_en,
    output logic [31:0]       ram_wr_data,
    input  logic [31:0]       ram_rd_data
);

    typedef enum logic {IDLE, RMW} state_t;

    state_t            state;
    logic              ptr;
    logic [ADDR_W-3:0] addr_q;
    logic [31:0]       h_word;
    logic [1:0]        h_lane;
    logic              h_half;
    logic [15:0]       h_wdata;
    logic              h_id;

    logic              idle, grant0, grant1, accept;
    logic              s_we, s_signed, s_err;
    logic [1:0]        s_size, lane;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_data, merged;
    logic              rsp_fire, rsp_id, rsp_e;
    logic [31:0]       rsp_data;

    // No grant while reset is asserted, so nothing is accepted in a reset cycle.
    assign idle   = (state == IDLE) && !rst;
    assign grant1 = idle && m1_req_valid && (!m0_req_valid || ((RR_EN != 0) && ptr));
    assign grant0 = idle && m0_req_valid && !grant1;
    assign accept = grant0 || grant1;
    assign m0_req_ready = grant0;
    assign m1_req_ready = grant1;

    assign s_we     = grant1 ? m1_req_we     : m0_req_we;
    assign s_size   = grant1 ? m1_req_size   : m0_req_size;
    assign s_signed = grant1 ? m1_req_signed : m0_req_signed;
    assign s_addr   = grant1 ? m1_req_addr   : m0_req_addr;
    assign s_wdata  = grant1 ? m1_req_wdata  : m0_req_wdata;
    assign lane     = s_addr[1:0];

    assign s_err = (s_size == 2'b11)
                || (s_size == 2'b01 && s_addr[0])
                || (s_size == 2'b10 && s_addr[1:0] != 2'b00);

    always_comb begin
        ld_byte = ram_rd_data[{lane, 3'b000} +: 8];
        ld_half = s_addr[1] ? ram_rd_data[31:16] : ram_rd_data[15:0];
        case (s_size)
            2'b00:   load_data = {{24{s_signed & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{s_signed & ld_half[15]}}, ld_half};
            default: load_data = ram_rd_data;
        endcase
    end

    always_comb begin
        merged = h_word;
        if (h_half)
            merged[{h_lane[1], 4'b0000} +: 16] = h_wdata;
        else
            merged[{h_lane, 3'b000} +: 8] = h_wdata[7:0];
    end

    // addr_q tracks ram_addr, so it is also the held word address during RMW.
    assign ram_addr    = accept ? s_addr[ADDR_W-1:2] : addr_q;
    assign ram_wr_en   = (accept && s_we && s_size == 2'b10 && !s_err)
                      || (state == RMW && !rst);
    assign ram_wr_data = (state == RMW) ? merged : s_wdata;

    always_comb begin
        rsp_fire = (state == RMW) || (accept && (s_err || !s_we || s_size == 2'b10));
        rsp_id   = (state == RMW) ? h_id : grant1;
        rsp_e    = (state != RMW) && s_err;
        rsp_data = ((state == RMW) || s_err || s_we) ? '0 : load_data;
    end

    always_ff @(posedge clk) begin
        addr_q       <= ram_addr;
        m0_rsp_valid <= 1'b0;
        m1_rsp_valid <= 1'b0;
        if (rst) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            m0_rsp_rdata <= '0;
            m0_rsp_err   <= 1'b0;
            m1_rsp_rdata <= '0;
            m1_rsp_err   <= 1'b0;
        end else begin
            if (rsp_fire) begin
                if (rsp_id) begin
                    m1_rsp_valid <= 1'b1;
                    m1_rsp_rdata <= rsp_data;
                    m1_rsp_err   <= rsp_e;
                end else begin
                    m0_rsp_valid <= 1'b1;
                    m0_rsp_rdata <= rsp_data;
                    m0_rsp_err   <= rsp_e;
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (RR_EN != 0)
                            ptr <= grant0;
                        if (s_we && !s_err && s_size != 2'b10) begin
                            state   <= RMW;
                            h_word  <= ram_rd_data;
                            h_lane  <= lane;
                            h_half  <= s_size[0];
                            h_wdata <= s_wdata[15:0];
                            h_id    <= grant1;
                        end
                    end
                end
                RMW:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_d_dram_arbiter.sv
// Bench for d_dram_arbiter: directed scenarios plus random traffic, checked each cycle
// against a transaction-level model of arbitration, responses and RAM contents.
module tb_d_dram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_req_signed;
    logic [1:0]  m0_req_size;
    logic [13:0] m0_req_addr;
    logic [31:0] m0_req_wdata;
    logic        m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_req_signed;
    logic [1:0]  m1_req_size;
    logic [13:0] m1_req_addr;
    logic [31:0] m1_req_wdata;
    logic        m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;
    logic [11:0] ram_addr;
    logic        ram_wr_en;
    logic [31:0] ram_wr_data, ram_rd_data;

    logic        fp_m0_req_ready, fp_m0_rsp_valid, fp_m0_rsp_err;
    logic        fp_m1_req_ready, fp_m1_rsp_valid, fp_m1_rsp_err;
    logic [31:0] fp_m0_rsp_rdata, fp_m1_rsp_rdata, fp_ram_wr_data;
    logic [11:0] fp_ram_addr;
    logic        fp_ram_wr_en;
    logic [31:0] fp_rd;
    assign fp_rd = '0;

    logic [31:0] ram [4096];
    assign ram_rd_data = ram[ram_addr];
    always @(posedge clk) if (ram_wr_en) ram[ram_addr] <= ram_wr_data;

    d_dram_arbiter #(.ADDR_W(14), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_size(m0_req_size), .m0_req_signed(m0_req_signed), .m0_req_addr(m0_req_addr),
        .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_size(m1_req_size), .m1_req_signed(m1_req_signed), .m1_req_addr(m1_req_addr),
        .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .m1_rsp_err(m1_rsp_err),
        .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data)
    );

    d_dram_arbiter #(.ADDR_W(14), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(fp_m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_size(m0_req_size), .m0_req_signed(m0_req_signed), .m0_req_addr(m0_req_addr),
        .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(fp_m0_rsp_valid),
        .m0_rsp_rdata(fp_m0_rsp_rdata), .m0_rsp_err(fp_m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(fp_m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_size(m1_req_size), .m1_req_signed(m1_req_signed), .m1_req_addr(m1_req_addr),
        .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(fp_m1_rsp_valid),
        .m1_rsp_rdata(fp_m1_rsp_rdata), .m1_rsp_err(fp_m1_rsp_err),
        .ram_addr(fp_ram_addr), .ram_wr_en(fp_ram_wr_en), .ram_wr_data(fp_ram_wr_data),
        .ram_rd_data(fp_rd)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [31:0] mem [4096];
    bit          busy, ptr, addr_known;
    int          b_id;
    logic [11:0] b_word, last_addr;
    logic [31:0] b_merged;
    bit          e_rv [2];
    bit          e_err [2];
    logic [31:0] e_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [13:0] a);
        logic [31:0] r;
        if (sz == 2'd0) begin
            r = (w >> (8 * a[1:0])) & 32'hFF;
            if (sg && r[7]) r = r | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            r = (w >> (16 * a[1])) & 32'hFFFF;
            if (sg && r[15]) r = r | 32'hFFFF_0000;
        end else begin
            r = w;
        end
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] sz,
                                          input logic [13:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int unsigned sh;
        sh   = (sz == 2'd0) ? 8 * a[1:0] : 16 * a[1];
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // One clock cycle: compare everything visible mid-cycle, then advance the model.
    task automatic cycle();
        bit          n_rv [2];
        bit          n_err [2];
        logic [31:0] n_rd [2];
        int          g;
        logic        we, sg, er;
        logic [1:0]  sz;
        logic [13:0] ad;
        logic [31:0] wd;
        logic [11:0] wa;
        n_rv = '{0, 0};
        n_err = '{0, 0};
        n_rd = '{32'h0, 32'h0};
        @(negedge clk);
        chk("m0_rsp_valid", m0_rsp_valid, e_rv[0]);
        chk("m1_rsp_valid", m1_rsp_valid, e_rv[1]);
        if (e_rv[0]) begin
            chk("m0_rsp_rdata", m0_rsp_rdata, e_rd[0]);
            chk("m0_rsp_err", m0_rsp_err, e_err[0]);
        end
        if (e_rv[1]) begin
            chk("m1_rsp_rdata", m1_rsp_rdata, e_rd[1]);
            chk("m1_rsp_err", m1_rsp_err, e_err[1]);
        end
        if (rst) begin
            chk("rst_ready0", m0_req_ready, 0);
            chk("rst_ready1", m1_req_ready, 0);
            chk("rst_wr_en", ram_wr_en, 0);
            busy = 0;
            ptr  = 0;
        end else if (busy) begin
            chk("rmw_ready0", m0_req_ready, 0);
            chk("rmw_ready1", m1_req_ready, 0);
            chk("rmw_wr_en", ram_wr_en, 1);
            chk("rmw_addr", ram_addr, b_word);
            chk("rmw_wdata", ram_wr_data, b_merged);
            mem[b_word] = b_merged;
            n_rv[b_id] = 1;
            busy = 0;
        end else begin
            g = -1;
            if (m0_req_valid && m1_req_valid) g = ptr ? 1 : 0;
            else if (m0_req_valid) g = 0;
            else if (m1_req_valid) g = 1;
            chk("ready0", m0_req_ready, g == 0);
            chk("ready1", m1_req_ready, g == 1);
            if (g < 0) begin
                chk("idle_wr_en", ram_wr_en, 0);
                if (addr_known) chk("hold_addr", ram_addr, last_addr);
            end else begin
                we = (g == 0) ? m0_req_we     : m1_req_we;
                sz = (g == 0) ? m0_req_size   : m1_req_size;
                sg = (g == 0) ? m0_req_signed : m1_req_signed;
                ad = (g == 0) ? m0_req_addr   : m1_req_addr;
                wd = (g == 0) ? m0_req_wdata  : m1_req_wdata;
                wa = ad[13:2];
                chk("grant_addr", ram_addr, wa);
                last_addr  = wa;
                addr_known = 1;
                ptr = (g == 0);
                er = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 0);
                if (er) begin
                    chk("err_wr_en", ram_wr_en, 0);
                    n_rv[g] = 1;
                    n_err[g] = 1;
                end else if (!we) begin
                    chk("load_wr_en", ram_wr_en, 0);
                    n_rv[g] = 1;
                    n_rd[g] = ext_load(mem[wa], sz, sg, ad);
                end else if (sz == 2'd2) begin
                    chk("st_wr_en", ram_wr_en, 1);
                    chk("st_wdata", ram_wr_data, wd);
                    mem[wa] = wd;
                    n_rv[g] = 1;
                end else begin
                    chk("sub_wr_en", ram_wr_en, 0);
                    busy = 1;
                    b_id = g;
                    b_word = wa;
                    b_merged = merge(mem[wa], sz, ad, wd);
                end
            end
        end
        e_rv = n_rv;
        e_rd = n_rd;
        e_err = n_err;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_valid = 0; m0_req_we = 0; m0_req_size = 0; m0_req_signed = 0;
        m0_req_addr = 0; m0_req_wdata = 0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_size = 0; m1_req_signed = 0;
        m1_req_addr = 0; m1_req_wdata = 0;
    endtask

    task automatic req0(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [13:0] a, input logic [31:0] wd);
        m0_req_valid = 1; m0_req_we = we; m0_req_size = sz; m0_req_signed = sg;
        m0_req_addr = a; m0_req_wdata = wd;
    endtask

    task automatic req1(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [13:0] a, input logic [31:0] wd);
        m1_req_valid = 1; m1_req_we = we; m1_req_size = sz; m1_req_signed = sg;
        m1_req_addr = a; m1_req_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = '0;
            mem[i] = '0;
        end
        busy = 0; ptr = 0; addr_known = 0; b_id = 0;
        b_word = '0; b_merged = '0; last_addr = '0;
        e_rv = '{0, 0}; e_err = '{0, 0}; e_rd = '{32'h0, 32'h0};
        rst = 1;
        idle_inputs();
        cycle();
        cycle();
        rst = 0;
        chk("reset_m0_rdata", m0_rsp_rdata, 32'h0);
        chk("reset_m1_rdata", m1_rsp_rdata, 32'h0);
        chk("reset_m0_valid", m0_rsp_valid, 0);
        chk("reset_m1_err", m1_rsp_err, 0);
        cycle();

        req0(1, 2'd2, 0, 14'h010, 32'hDEAD_BEEF);
        cycle();
        idle_inputs();
        chk("word_store_ram", ram[4], 32'hDEAD_BEEF);
        req0(0, 2'd2, 0, 14'h010, 32'h0);
        cycle();
        idle_inputs();
        chk("word_load_data", m0_rsp_rdata, 32'hDEAD_BEEF);

        req0(1, 2'd0, 0, 14'h012, 32'hAAAA_AA55);
        cycle();
        idle_inputs();
        cycle();
        chk("byte_rmw_ram", ram[4], 32'hDE55_BEEF);
        cycle();

        req0(0, 2'd0, 1, 14'h013, 32'h0);
        cycle();
        chk("sbyte_load", m0_rsp_rdata, 32'hFFFF_FFDE);
        req0(0, 2'd1, 0, 14'h012, 32'h0);
        cycle();
        idle_inputs();
        chk("uhalf_load", m0_rsp_rdata, 32'h0000_DE55);

        rst = 1;
        cycle();
        rst = 0;
        req0(0, 2'd2, 0, 14'h010, 32'h0);
        req1(0, 2'd2, 0, 14'h020, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("fp_m0_ready", fp_m0_req_ready, 1);
            chk("fp_m1_starved", fp_m1_req_ready, 0);
        end
        m0_req_valid = 0;
        #1;
        chk("fp_m1_after_drop", fp_m1_req_ready, 1);
        cycle();
        idle_inputs();

        req1(0, 2'd1, 0, 14'h011, 32'h0);
        cycle();
        idle_inputs();
        chk("err_half_flag", m1_rsp_err, 1);
        chk("err_half_rdata", m1_rsp_rdata, 32'h0);
        req0(1, 2'd2, 0, 14'h012, 32'h1234_5678);
        cycle();
        idle_inputs();
        chk("err_word_flag", m0_rsp_err, 1);
        req0(1, 2'd3, 0, 14'h010, 32'h1234_5678);
        cycle();
        idle_inputs();
        chk("err_size_flag", m0_rsp_err, 1);
        chk("err_ram_intact", ram[4], 32'hDE55_BEEF);

        req0(1, 2'd0, 0, 14'h014, 32'h0000_0077);
        cycle();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
        req0(0, 2'd2, 0, 14'h014, 32'h0);
        cycle();
        idle_inputs();
        chk("rst_drop_ram", ram[5], 32'h0);
        cycle();

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            m0_req_valid = $urandom_range(0, 1);
            m0_req_we = $urandom_range(0, 1);
            m0_req_size = 2'($urandom_range(0, 3));
            m0_req_signed = $urandom_range(0, 1);
            m0_req_addr = 14'($urandom_range(0, 31));
            m0_req_wdata = $urandom;
            m1_req_valid = $urandom_range(0, 1);
            m1_req_we = $urandom_range(0, 1);
            m1_req_size = 2'($urandom_range(0, 3));
            m1_req_signed = $urandom_range(0, 1);
            m1_req_addr = 14'($urandom_range(0, 31));
            m1_req_wdata = $urandom;
            cycle();
        end
        rst = 0;
        idle_inputs();
        cycle();
        cycle();
        for (int w = 0; w < 8; w++) chk("final_ram", ram[w], mem[w]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_dram_arbiter.md
Name: d_dram_arbiter

Overview:
Two-requester arbiter and sub-word access sequencer for the single-port data RAM (32-bit words, async read, sync write). Port m0 is the CPU load/store unit and port m1 is the DMA/debug master. The block grants one byte-addressed request per cycle, performs load byte-lane extraction and sign/zero extension, and performs byte/halfword stores as a two-cycle read-modify-write. It sits between the LSU/debug fabric and the data RAM.

Parameters:
ADDR_W, 14, byte-address width; the RAM word address is addr[ADDR_W-1:2] (12 bits, 4096 words)
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with m0 highest

Ports:
clk  input  1  single clock; everything is sampled on posedge
rst  input  1  synchronous, active-high reset
mN_req_valid  input  1  request valid (N = 0,1, same set per port)
mN_req_ready  output  1  request accepted when valid&ready at posedge
mN_req_we  input  1  1 = store, 0 = load
mN_req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
mN_req_signed  input  1  sign-extend load result (byte/half only)
mN_req_addr  input  ADDR_W  byte address
mN_req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
mN_rsp_valid  output  1  one-cycle response pulse; no backpressure
mN_rsp_rdata  output  32  load data, extended; 0 for stores/errors
mN_rsp_err  output  1  misaligned or illegal size
ram_addr  output  ADDR_W-2  RAM word address
ram_wr_en  output  1  RAM write strobe
ram_wr_data  output  32  RAM write data
ram_rd_data  input  32  RAM async read data

Behaviour:
- States: IDLE and RMW. Reset forces IDLE, all rsp_valid/rsp_err = 0, rsp_rdata = 0, ram_wr_en = 0, priority pointer = m0.
- Grant, IDLE only, combinational. Requester sets: only one valid -> grant it; both valid -> grant the pointer's port (RR_EN = 1) or m0 (RR_EN = 0). Only the granted port sees ready = 1. In RMW both ready = 0.
- Pointer: on every accept with RR_EN = 1, the pointer moves to the non-granted port.
- ram_addr = granted addr[ADDR_W-1:2] in IDLE, or the held word address in RMW. When nothing is granted it holds its last value.
- Error check at accept. Size 11, half with addr[0] = 1, or word with addr[1:0] != 0 -> no RAM write, rsp_err = 1, rdata = 0, rsp_valid in T+1. State stays IDLE.
- Load accepted in cycle T:
  - Lane k = addr[1:0] (half uses addr[1]) selects bits from ram_rd_data in T.
  - Extend per signed, register the result, pulse rsp_valid in T+1.
  - Latency is 1 and throughput is 1 per cycle.
- Word store accepted in T: ram_wr_en = 1 and ram_wr_data = wdata in T. rsp_valid in T+1.
- Byte/half store accepted in T:
  - Capture ram_rd_data, word address, lane, size, wdata and requester ID. Go to RMW.
  - In T+1: ram_wr_en = 1, ram_wr_data = captured word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. Return to IDLE.
  - rsp_valid in T+2. The port can accept a new request in T+2 at the earliest.
- Responses route only to the originating port. Both ports may never have rsp_valid in the same cycle.
- ram_wr_en is 0 in every cycle other than those listed above.
- rst asserted during RMW: the pending write is dropped (ram_wr_en = 0 in that cycle), no response is issued, state returns to IDLE.
- A request whose valid drops before it is granted is not tracked. Once accepted, a request is independent of later input changes.

Test Plan:
- Reset, then m0 word store 0xDEADBEEF @0x010, then load word @0x010 -> ram_wr_en at word 4 in the accept cycle; load rsp_rdata = 0xDEADBEEF one cycle after accept, rsp_err = 0.
- Word 4 = 0xDEADBEEF; byte store 0x55 @0x012 -> m0 ready low for one cycle; RAM write 0xDE55BEEF in T+1; rsp_valid in T+2.
- Signed byte load @0x013 of 0xDE55BEEF -> 0xFFFFFFDE. Unsigned half load @0x012 -> 0x0000DE55.
- Both ports issue continuous word loads -> grants alternate m0, m1, m0, …. With RR_EN = 0, m1 is starved until m0 drops valid.
- Half load @0x011, word store @0x012, size 11 -> each gives rsp_err = 1 and rdata = 0; RAM is unchanged and ram_wr_en is never asserted.
- Byte store accepted, then rst pulsed in T+1 -> no RAM write, no rsp_valid, both ports ready again in the next cycle after rst deasserts.
